// File: rtl/param_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | param_sync_fifo : single-clock FIFO, registered flags, optional FWFT     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module param_sync_fifo #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 4,
   parameter int ALMOST_FULL_TH  = 14,
   parameter int ALMOST_EMPTY_TH = 2,
   parameter int FWFT            = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_en,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   input  logic                  read_en,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int                c_depth_int = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_depth   = (ADDR_WIDTH+1)'(c_depth_int);
   localparam logic [ADDR_WIDTH:0] c_af_th   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
   localparam logic [ADDR_WIDTH:0] c_ae_th   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

   logic [DATA_WIDTH-1:0] r_mem [0:c_depth_int-1];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_almost_full;
   logic                  r_empty;
   logic                  r_almost_empty;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   // Acceptance uses the registered flags, so on full a read frees no slot for a write in the same cycle
   assign w_wr_acc = write_en & ~r_full  & ~reset;
   assign w_rd_acc = read_en  & ~r_empty & ~reset;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc)
         w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
      else if (w_rd_acc && !w_wr_acc)
         w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_almost_full  <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == c_depth);
         r_almost_full  <= (w_count_nxt >= c_af_th);
         r_empty        <= (w_count_nxt == '0);
         r_almost_empty <= (w_count_nxt <= c_ae_th);
         r_overflow     <= write_en & r_full;
         r_underflow    <= read_en & r_empty;
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= write_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign read_data = r_mem[r_rd_ptr];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_read_data;
         always_ff @(posedge clk) begin
            if (reset)
               r_read_data <= '0;
            else if (w_rd_acc)
               r_read_data <= r_mem[r_rd_ptr];
         end
         assign read_data = r_read_data;
      end
   endgenerate

   assign full         = r_full;
   assign almost_full  = r_almost_full;
   assign overflow     = r_overflow;
   assign empty        = r_empty;
   assign almost_empty = r_almost_empty;
   assign underflow    = r_underflow;
   assign count        = r_count;

endmodule
`default_nettype wire
